// File: rtl/countdown_ctrl_pkg.sv
// Shared types and constants for the countdown controller: FSM state encoding,
// default counter width and the registered status bundle.
package countdown_ctrl_pkg;

  localparam int CD_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } cd_state_e;

  typedef struct packed {
    logic busy;
    logic done;
    logic tc;
  } cd_status_t;

  // Status flags are a pure function of the next state plus the tc decision,
  // so registering this bundle keeps every output aligned with the state.
  function automatic cd_status_t status_of(cd_state_e st, logic tc);
    cd_status_t s;
    s.busy = (st == ST_RUN) || (st == ST_PAUSE);
    s.done = (st == ST_DONE);
    s.tc   = tc;
    return s;
  endfunction

endpackage

// File: rtl/countdown_ctrl_if.sv
// Control/status bundle between a countdown controller and its client.
interface countdown_ctrl_if
  import countdown_ctrl_pkg::*;
#(
  parameter int WIDTH = CD_WIDTH
) ();

  logic             start;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output start, pause, abort, load_val,
    input  count, busy, tc, done
  );

  modport slave (
    input  start, pause, abort, load_val,
    output count, busy, tc, done
  );

endinterface

// File: rtl/down_counter_ld.sv
// Loadable down counter; load beats en, and en saturates at zero.
module down_counter_ld #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= d;
    end else if (en && (q_q != '0)) begin
      q_q <= q_q - WIDTH'(1);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown controller: IDLE/RUN/PAUSE/DONE FSM sequencing a loadable down
// counter, with optional auto-reload and a one-cycle terminal-count pulse.
module countdown_ctrl
  import countdown_ctrl_pkg::*;
#(
  parameter int WIDTH       = CD_WIDTH,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  countdown_ctrl_if.slave bus
);

  cd_state_e        state_q, state_d;
  cd_status_t       sts_q;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             cnt_load, cnt_en, tc_d;
  logic             lv_zero;

  assign lv_zero = (bus.load_val == '0);

  // Priority: abort > start > pause > decrement.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_d    = bus.load_val;
    tc_d     = 1'b0;
    if (bus.abort) begin
      state_d  = ST_IDLE;
      cnt_load = 1'b1;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            cnt_load = 1'b1;
            state_d  = lv_zero ? ST_DONE : ST_RUN;
            tc_d     = lv_zero;
          end
        end
        ST_RUN: begin
          if (bus.pause) begin
            state_d = ST_PAUSE;
          end else if (cnt_q > WIDTH'(1)) begin
            cnt_en = 1'b1;
          end else if (cnt_q == WIDTH'(1)) begin
            cnt_en  = 1'b1;
            tc_d    = 1'b1;
            state_d = AUTO_RELOAD ? ST_RUN : ST_DONE;
          end else begin
            // Zero in RUN only occurs with auto-reload, one cycle after tc.
            if (AUTO_RELOAD && !lv_zero) begin
              cnt_load = 1'b1;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_PAUSE: begin
          if (!bus.pause) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sts_q   <= '0;
    end else begin
      state_q <= state_d;
      sts_q   <= status_of(state_d, tc_d);
    end
  end

  down_counter_ld #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .d    (cnt_d),
    .q    (cnt_q)
  );

  assign bus.count = cnt_q;
  assign bus.busy  = sts_q.busy;
  assign bus.done  = sts_q.done;
  assign bus.tc    = sts_q.tc;

endmodule

// File: doc/countdown_ctrl.md
COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits.
REQ-002 SHALL have parameter AUTO_RELOAD, default 0: 1 = reload and keep running after terminal count.
REQ-003 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1: begin countdown from load_val.
REQ-006 SHALL have port pause  input  1: level, hold count while high.
REQ-007 SHALL have port abort  input  1: cancel operation, return to IDLE.
REQ-008 SHALL have port load_val  input  WIDTH: countdown start value, sampled on start and on each auto-reload.
REQ-009 SHALL have port count  output  WIDTH: current counter value.
REQ-010 SHALL have port busy  output  1: high in RUN or PAUSE.
REQ-011 SHALL have port tc  output  1: one-cycle terminal-count pulse.
REQ-012 SHALL have port done  output  1: high in DONE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-014 Priority on every edge SHALL be abort > start > pause > decrement.
REQ-015 abort=1 in any state SHALL give state IDLE, count 0, tc 0 at next edge.
REQ-016 IDLE or DONE with start=1, load_val!=0: next edge count=load_val, state RUN.
REQ-017 IDLE or DONE with start=1, load_val==0: next edge count=0, state DONE, tc=1 for one cycle.
REQ-018 start SHALL be ignored in RUN and PAUSE.
REQ-019 RUN, pause=0, count>1: count decrements by 1 per edge.
REQ-020 RUN, pause=0, count==1: next edge count=0, tc=1 for exactly one cycle; state DONE if AUTO_RELOAD=0, else stays RUN.
REQ-021 AUTO_RELOAD=1, RUN, count==0, pause=0: next edge count=load_val (no decrement) if load_val!=0, else state DONE with no extra tc; period = L+1 cycles.
REQ-022 Latency: start sampled at edge N with load_val=L>0 SHALL give tc high after edge N+L, count=0 then.
REQ-023 RUN with pause=1: next edge state PAUSE, count held; PAUSE with pause=1 holds.
REQ-024 PAUSE with pause=0: next edge state RUN, count still held; decrement resumes the edge after.
REQ-025 start and pause both high in IDLE: start wins; pause effective from next edge.
REQ-026 Counter SHALL never wrap below 0; tc SHALL be 0 in all cases not listed above.
REQ-027 DONE SHALL persist until start or abort.

Reset
REQ-028 rst low SHALL immediately force state IDLE, count 0, busy 0, tc 0, done 0, independent of clk.
REQ-029 Reset deassertion SHALL take effect on the first rising clk edge after rst goes high; no input acted on earlier.
REQ-030 Reset mid-countdown SHALL discard count; no tc generated.

Structure
REQ-031 Package countdown_ctrl_pkg SHALL hold the state enum and default WIDTH constant.
REQ-032 Counter datapath SHALL be sub-module down_counter_ld (ports clk, rst, load, en, d, q), sequenced by the FSM via load/en.

Verification
REQ-033 Reset, start with load_val=5 -> count 5,4,3,2,1,0 on successive edges; tc single pulse with count=0; done=1; busy=0.
REQ-034 load_val=4, pause high 3 cycles at count=2 -> count stays 2 for 4 edges (3 paused + 1 resume), then 1,0; tc once.
REQ-035 AUTO_RELOAD=1, load_val=3 -> count 3,2,1,0,3,2,1,0; tc every 4 cycles; done stays 0.
REQ-036 abort and start asserted together at count=3 -> count 0, state IDLE, tc never asserted.
REQ-037 start with load_val=0 -> done=1 and tc=1 for one cycle after next edge; busy never 1.
REQ-038 rst pulsed low asynchronously mid-count at count=6 -> outputs 0 before next clk edge; start ignored until first edge after release.
